// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

  function automatic int calc_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_REGISTERS = 32;
  localparam int DEF_IW            = calc_iw(DEF_NUM_REGISTERS);

  typedef logic [DEF_IW-1:0]         reg_idx_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: stored-value mux, priority bypass from the
// write ports, and the matching busy adjustment.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int NUM_REGISTERS   = DEF_NUM_REGISTERS,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int BYPASS          = 1,
  localparam int IW             = calc_iw(NUM_REGISTERS)
) (
  input  logic                                 rst,
  input  logic [IW-1:0]                        rd_addr,
  input  logic [NUM_REGISTERS*DATA_WIDTH-1:0]  stored_flat,
  input  logic [NUM_REGISTERS-1:0]             busy_vec,
  input  logic [NUM_WRITE_PORTS-1:0]           wr_en,
  input  logic [NUM_WRITE_PORTS*IW-1:0]        wr_addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                                 rsv_en,
  input  logic [IW-1:0]                        rsv_addr,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_busy
);

  localparam int DW = DATA_WIDTH;

  logic          bypass_on;
  logic [DW-1:0] stored_val;
  logic          stored_busy;
  logic [DW-1:0] fwd_val;
  logic          fwd_hit;

  assign bypass_on = (BYPASS != 0);

  always_comb begin
    stored_val  = '0;
    stored_busy = 1'b0;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      if (rd_addr == IW'(r)) begin
        stored_val  = stored_flat[r*DW +: DW];
        stored_busy = busy_vec[r];
      end
    end
  end

  // Ascending scan so the highest-indexed matching port is the one left standing.
  always_comb begin
    fwd_val = '0;
    fwd_hit = 1'b0;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (wr_en[p] && (wr_addr[p*IW +: IW] == rd_addr)) begin
        fwd_val = wr_data[p*DW +: DW];
        fwd_hit = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = stored_val;
    rd_busy = stored_busy;
    if (bypass_on && rst && (rd_addr != IW'(ZERO_REG))) begin
      if (fwd_hit) begin
        rd_data = fwd_val;
        rd_busy = 1'b0;
      end
      // A same-cycle reservation names a newer producer than the write.
      if (rsv_en && (rsv_addr == rd_addr)) begin
        rd_busy = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// N-read / M-write register file with write bypass and a pending-write
// scoreboard; entry 0 is hardwired to zero and never busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int NUM_REGISTERS   = DEF_NUM_REGISTERS,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int BYPASS          = 1,
  localparam int IW             = calc_iw(NUM_REGISTERS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_READ_PORTS*IW-1:0]          rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ_PORTS-1:0]             rd_busy,
  input  logic [NUM_WRITE_PORTS-1:0]            wr_en,
  input  logic [NUM_WRITE_PORTS*IW-1:0]         wr_addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                                  rsv_en,
  input  logic [IW-1:0]                         rsv_addr,
  output logic [IW:0]                           busy_count
);

  localparam int DW = DATA_WIDTH;

  logic [NUM_REGISTERS*DW-1:0] stored_flat;
  logic [NUM_REGISTERS-1:0]    busy_q;
  logic [NUM_REGISTERS-1:0]    busy_d;
  logic [IW:0]                 busy_count_q;
  logic [IW:0]                 busy_count_d;

  for (genvar gi = 0; gi < NUM_REGISTERS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign stored_flat[DW-1:0] = '0;
      assign busy_d[0]           = 1'b0;
    end else begin : g_entry
      logic [DW-1:0] data_q;
      logic [DW-1:0] data_d;
      logic          wr_hit;

      always_comb begin
        data_d = data_q;
        wr_hit = 1'b0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          if (wr_en[p] && (wr_addr[p*IW +: IW] == IW'(gi))) begin
            data_d = wr_data[p*DW +: DW];
            wr_hit = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      // Reservation dominates a same-cycle write release.
      assign busy_d[gi] = rst && ((busy_q[gi] && !wr_hit) ||
                                  (rsv_en && (rsv_addr == IW'(gi))));
      assign stored_flat[gi*DW +: DW] = data_q;
    end
  end

  always_comb begin
    busy_count_d = '0;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      busy_count_d = busy_count_d + (IW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
    regfile_read_port #(
      .DATA_WIDTH      (DATA_WIDTH),
      .NUM_REGISTERS   (NUM_REGISTERS),
      .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
      .BYPASS          (BYPASS)
    ) u_rd (
      .rst         (rst),
      .rd_addr     (rd_addr[gi*IW +: IW]),
      .stored_flat (stored_flat),
      .busy_vec    (busy_q),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rsv_en      (rsv_en),
      .rsv_addr    (rsv_addr),
      .rd_data     (rd_data[gi*DW +: DW]),
      .rd_busy     (rd_busy[gi])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [5:0]  busy_count, busy_count_nb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_count(busy_count)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_count(busy_count_nb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en  = 2'b00;
    rsv_en = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]          = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic set_rsv(input logic [4:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic test_reset;
    rst = 1'b0; idle(); rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_rd(0, 5'(i)); set_rd(1, 5'(31 - i)); #1;
      n_cmp++;
      if ({rd_data, rd_busy} !== 66'd0) begin
        n_err++; $display("FAIL reset_read idx %0d: got data %h busy %b, want 0", i, rd_data, rd_busy);
      end
    end
    n_cmp++;
    if (busy_count !== 6'd0 || busy_count_nb !== 6'd0) begin
      n_err++; $display("FAIL reset_count: got %0d/%0d, want 0", busy_count, busy_count_nb);
    end
    $display("reset: all indices read");
    tick();
  endtask

  task automatic test_reserve_write;
    idle(); set_rsv(5'd5); set_rd(0, 5'd5); #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL rsv_same_cycle_busy: got %b want 1", rd_busy[0]); end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL rsv_busy: got %b want 1", rd_busy[0]); end
    n_cmp++;
    if (busy_count !== 6'd1) begin n_err++; $display("FAIL rsv_count: got %0d want 1", busy_count); end
    set_wr(0, 5'd5, 32'hDEAD_BEEF); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL wr_bypass: got %h/%b want deadbeef/0", rd_data[31:0], rd_busy[0]);
    end
    n_cmp++;
    if (rd_data_nb[31:0] !== 32'h0 || rd_busy_nb[0] !== 1'b1) begin
      n_err++; $display("FAIL wr_nobypass: got %h/%b want 0/1", rd_data_nb[31:0], rd_busy_nb[0]);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_busy[0] !== 1'b0 || busy_count !== 6'd0) begin
      n_err++; $display("FAIL wr_commit: got %h/%b/%0d want deadbeef/0/0", rd_data[31:0], rd_busy[0], busy_count);
    end
    $display("reserve_write: r5 reserved then written");
    tick();
  endtask

  task automatic test_same_index;
    idle(); set_wr(0, 5'd7, 32'h1111); set_wr(1, 5'd7, 32'h2222); set_rd(1, 5'd7); #1;
    n_cmp++;
    if (rd_data[63:32] !== 32'h2222) begin n_err++; $display("FAIL prio_bypass: got %h want 2222", rd_data[63:32]); end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data[63:32] !== 32'h2222 || rd_data_nb[63:32] !== 32'h2222) begin
      n_err++; $display("FAIL prio_stored: got %h/%h want 2222", rd_data[63:32], rd_data_nb[63:32]);
    end
    $display("same_index: r7 double write");
    tick();
  endtask

  task automatic test_zero_reg;
    idle(); set_wr(0, 5'd0, 32'hFFFF_FFFF); set_rsv(5'd0); set_rd(0, 5'd0); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL zero_bypass: got %h/%b want 0/0", rd_data[31:0], rd_busy[0]);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_count !== 6'd0) begin
      n_err++; $display("FAIL zero_stored: got %h/%b/%0d want 0/0/0", rd_data[31:0], rd_busy[0], busy_count);
    end
    $display("zero_reg: r0 write+reserve dropped");
    tick();
  endtask

  task automatic test_rsv_write_same;
    idle(); set_rsv(5'd3); set_wr(1, 5'd3, 32'h42); set_rd(0, 5'd3); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h42 || rd_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL rsvwr_bypass: got %h/%b want 42/1", rd_data[31:0], rd_busy[0]);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h42 || rd_busy[0] !== 1'b1 || busy_count !== 6'd1) begin
      n_err++; $display("FAIL rsvwr_stored: got %h/%b/%0d want 42/1/1", rd_data[31:0], rd_busy[0], busy_count);
    end
    for (int r = 1; r < 32; r++) begin
      set_rsv(5'(r)); tick();
    end
    idle(); set_rd(1, 5'd31); #1;
    n_cmp++;
    if (busy_count !== 6'd31 || busy_count_nb !== 6'd31) begin
      n_err++; $display("FAIL rsv_all_count: got %0d/%0d want 31", busy_count, busy_count_nb);
    end
    n_cmp++;
    if (rd_busy !== 2'b11 || rd_data[31:0] !== 32'h42) begin
      n_err++; $display("FAIL rsv_all_read: got busy %b r3 %h want 11/42", rd_busy, rd_data[31:0]);
    end
    $display("rsv_write_same: r3 plus sweep r1..r31");
    tick();
  endtask

  task automatic test_reset_mid;
    idle(); set_rsv(5'd9); tick();
    idle(); set_wr(0, 5'd9, 32'h55); tick();
    idle(); set_rd(0, 5'd9); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h55 || rd_busy[0] !== 1'b0 || busy_count !== 6'd30) begin
      n_err++; $display("FAIL r9_write: got %h/%b/%0d want 55/0/30", rd_data[31:0], rd_busy[0], busy_count);
    end
    rst = 1'b0; set_wr(1, 5'd10, 32'h77); set_rsv(5'd11); set_rd(0, 5'd10); set_rd(1, 5'd11); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL rst_suppress: got %h/%b want 0/1", rd_data[31:0], rd_busy[0]);
    end
    tick(); rst = 1'b1; idle(); #1;
    n_cmp++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || busy_count !== 6'd0) begin
      n_err++; $display("FAIL mid_reset: got %h/%b/%0d want 0/0/0", rd_data, rd_busy, busy_count);
    end
    set_rd(0, 5'd9); set_rd(1, 5'd5); #1;
    n_cmp++;
    if (rd_data !== 64'd0) begin n_err++; $display("FAIL mid_reset_regs: got %h want 0", rd_data); end
    set_wr(0, 5'd9, 32'h99); tick(); idle(); #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h99 || rd_busy[0] !== 1'b0 || busy_count !== 6'd0) begin
      n_err++; $display("FAIL post_reset_write: got %h/%b/%0d want 99/0/0", rd_data[31:0], rd_busy[0], busy_count);
    end
    $display("reset_mid: reservations discarded");
    tick();
  endtask

  task automatic test_no_bypass;
    idle(); set_wr(0, 5'd12, 32'hAAAA); tick();
    idle(); set_wr(0, 5'd12, 32'hBBBB); set_rsv(5'd12); set_rd(0, 5'd12); #1;
    n_cmp++;
    if (rd_data_nb[31:0] !== 32'hAAAA || rd_busy_nb[0] !== 1'b0) begin
      n_err++; $display("FAIL nb_same_cycle: got %h/%b want aaaa/0", rd_data_nb[31:0], rd_busy_nb[0]);
    end
    n_cmp++;
    if (rd_data[31:0] !== 32'hBBBB || rd_busy[0] !== 1'b1) begin
      n_err++; $display("FAIL byp_same_cycle: got %h/%b want bbbb/1", rd_data[31:0], rd_busy[0]);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data_nb[31:0] !== 32'hBBBB || rd_busy_nb[0] !== 1'b1 || busy_count_nb !== 6'd1) begin
      n_err++; $display("FAIL nb_commit: got %h/%b/%0d want bbbb/1/1", rd_data_nb[31:0], rd_busy_nb[0], busy_count_nb);
    end
    $display("no_bypass: r12 old value visible");
    tick();
  endtask

  task automatic test_back_to_back;
    idle(); set_wr(0, 5'd20, 32'h1); set_wr(1, 5'd21, 32'h2); tick();
    idle(); set_wr(1, 5'd20, 32'h3); set_rd(0, 5'd20); set_rd(1, 5'd21); #1;
    n_cmp++;
    if (rd_data !== {32'h2, 32'h3} || rd_data_nb[31:0] !== 32'h1) begin
      n_err++; $display("FAIL b2b_read: got %h nb %h want 00000002_00000003 nb 1", rd_data, rd_data_nb[31:0]);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data !== {32'h2, 32'h3} || rd_data_nb !== {32'h2, 32'h3}) begin
      n_err++; $display("FAIL b2b_commit: got %h/%h want 00000002_00000003", rd_data, rd_data_nb);
    end
    $display("back_to_back: r20/r21 consecutive writes");
    tick();
  endtask

  initial begin
    test_reset();
    test_reserve_write();
    test_same_index();
    test_zero_reg();
    test_rsv_write_same();
    test_reset_mid();
    test_no_bypass();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
